// File: rtl/dice_roller_multi_pkg.sv
// Shared types and helpers for the multi-die roller: FSM states, widths,
// LFSR polynomial and the rejection-sampling arithmetic.
package dice_pkg;

  localparam int unsigned DIE_W  = 8;
  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    DONE
  } state_t;

  // Largest multiple of sides not above 256; samples at or above it are rejected.
  function automatic logic [8:0] accept_limit(input logic [DIE_W-1:0] sides);
    logic [8:0] s9;
    s9 = {1'b0, sides};
    if (sides == '0) return '0;
    return (9'd256 / s9) * s9;
  endfunction

  function automatic logic [DIE_W-1:0] face_of(input logic [DIE_W-1:0] r,
                                               input logic [DIE_W-1:0] sides);
    if (sides == '0) return '0;
    return (r % sides) + DIE_W'(1);
  endfunction

endpackage

// File: rtl/dice_roller_multi_if.sv
// Request/result bundle between game control (master) and the roller (slave).
interface dice_roller_multi_if
  import dice_pkg::*;
#(
  parameter int unsigned NUM_DICE  = 4,
  parameter int unsigned MAX_SIDES = 20
);

  localparam int unsigned CNT_W = $clog2(NUM_DICE + 1);
  localparam int unsigned SUM_W = $clog2(NUM_DICE * MAX_SIDES + 1);

  logic                      roll;
  logic [DIE_W-1:0]          sides;
  logic [CNT_W-1:0]          count;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [NUM_DICE*DIE_W-1:0] dice_values;
  logic [SUM_W-1:0]          total;

  modport master (
    output roll, sides, count,
    input  busy, done, error, dice_values, total
  );

  modport slave (
    input  roll, sides, count,
    output busy, done, error, dice_values, total
  );

endinterface

// File: rtl/dice_roller_multi_lfsr.sv
// Free-running 32-bit Galois LFSR (x^32+x^22+x^2+x+1). With
// DICE_ROLLER_SEED_LOAD_EN defined, seed_load reloads it from seed_data.
module dice_lfsr
  import dice_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE11234
) (
  input  logic              clock,
  input  logic              reset,
`ifdef DICE_ROLLER_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_data,
`endif
  output logic [LFSR_W-1:0] lfsr
);

  // An all-zero state would lock the register, so zero seeds become 1.
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

  logic [LFSR_W-1:0] advanced;

  assign advanced = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= SEED_EFF;
    end else begin
`ifdef DICE_ROLLER_SEED_LOAD_EN
      if (seed_load) lfsr <= (seed_data == '0) ? LFSR_W'(1) : seed_data;
      else           lfsr <= advanced;
`else
      lfsr <= advanced;
`endif
    end
  end

endmodule

// File: rtl/dice_roller_multi.sv
// Multi-die roller: rejection-sampled faces from a shared LFSR, results and sum
// published atomically with a done pulse. Optional macro: DICE_ROLLER_SEED_LOAD_EN.
module dice_roller_multi
  import dice_pkg::*;
#(
  parameter int unsigned       NUM_DICE  = 4,
  parameter int unsigned       MAX_SIDES = 20,
  parameter logic [LFSR_W-1:0] SEED      = 32'hACE11234
) (
  input  logic              clock,
  input  logic              reset,
`ifdef DICE_ROLLER_SEED_LOAD_EN
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_data,
`endif
  dice_roller_multi_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NUM_DICE + 1);
  localparam int unsigned SUM_W = $clog2(NUM_DICE * MAX_SIDES + 1);
  localparam int unsigned DV_W  = NUM_DICE * DIE_W;

  state_t            state, state_next;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;
  logic [DIE_W-1:0]  sample, face, sides_q;
  logic [8:0]        limit;
  logic [CNT_W-1:0]  count_q, idx;
  logic [DV_W-1:0]   work, work_next, dice_values_q;
  logic [SUM_W-1:0]  acc, total_q;
  logic              error_q, req_ok, start, accept, last;

  dice_lfsr #(.SEED(SEED)) u_lfsr (
    .clock     (clock),
    .reset     (reset),
`ifdef DICE_ROLLER_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed_data (seed_data),
`endif
    .lfsr      (lfsr)
  );

  assign sample      = lfsr[DIE_W-1:0];
  assign lfsr_unused = ^lfsr[LFSR_W-1:DIE_W];
  assign limit       = accept_limit(sides_q);
  assign face        = face_of(sample, sides_q);

  assign req_ok = (bus.sides >= DIE_W'(2)) && (bus.sides <= DIE_W'(MAX_SIDES)) &&
                  (bus.count >= CNT_W'(1)) && (bus.count <= CNT_W'(NUM_DICE));
  assign start  = (state == IDLE) && bus.roll && req_ok;
  assign accept = (state == ROLL) && ({1'b0, sample} < limit);
  assign last   = (idx == count_q - CNT_W'(1));

  always_comb begin
    work_next = work;
    for (int unsigned i = 0; i < NUM_DICE; i++) begin
      if (idx == CNT_W'(i)) work_next[DIE_W*i +: DIE_W] = face;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ROLL;
      ROLL:    if (accept && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are registered on the final accept so they are already stable
  // throughout the DONE cycle in which done is raised.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sides_q       <= '0;
      count_q       <= '0;
      idx           <= '0;
      work          <= '0;
      acc           <= '0;
      dice_values_q <= '0;
      total_q       <= '0;
      error_q       <= 1'b0;
    end else begin
      error_q <= (state == IDLE) && bus.roll && !req_ok;
      if (start) begin
        sides_q <= bus.sides;
        count_q <= bus.count;
        idx     <= '0;
        work    <= '0;
        acc     <= '0;
      end else if (accept) begin
        work <= work_next;
        acc  <= acc + SUM_W'(face);
        idx  <= idx + CNT_W'(1);
        if (last) begin
          dice_values_q <= work_next;
          total_q       <= acc + SUM_W'(face);
        end
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.error       = error_q;
  assign bus.dice_values = dice_values_q;
  assign bus.total       = total_q;

endmodule

// File: tb/tb_dice_roller_multi.sv
// Directed bench for dice_roller_multi with an LFSR reference running in step with the DUT.
module tb_dice_roller_multi;

  localparam int unsigned NUM_DICE  = 4;
  localparam int unsigned MAX_SIDES = 20;
  localparam logic [31:0] SEED      = 32'hACE11234;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] m_lfsr;

  dice_roller_multi_if #(.NUM_DICE(NUM_DICE), .MAX_SIDES(MAX_SIDES)) bus ();

`ifdef DICE_ROLLER_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [31:0] seed_data = 32'h0;
`endif

  dice_roller_multi #(.NUM_DICE(NUM_DICE), .MAX_SIDES(MAX_SIDES), .SEED(SEED)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef DICE_ROLLER_SEED_LOAD_EN
    .seed_load (seed_load),
    .seed_data (seed_data),
`endif
    .bus       (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? 32'h80200003 : 32'h0);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // l is the LFSR value in the cycle roll is presented; samples start one step later.
  function automatic void predict(input logic [31:0] l, input int s, input int c,
                                  output logic [31:0] v, output int tot, output int cyc);
    int lim;
    int i;
    lim = (256 / s) * s;
    v = '0; tot = 0; cyc = 0; i = 0;
    while (i < c) begin
      l = lfsr_step(l);
      cyc++;
      if (int'(l[7:0]) < lim) begin
        v[8*i +: 8] = 8'(int'(l[7:0]) % s + 1);
        tot += int'(l[7:0]) % s + 1;
        i++;
      end
    end
  endfunction

  task automatic do_roll(input int s, input int c, output logic [31:0] dv, output int lat);
    logic [31:0] exp_v;
    int exp_tot, exp_cyc;
    @(negedge clock);
    predict(m_lfsr, s, c, exp_v, exp_tot, exp_cyc);
    bus.roll = 1'b1; bus.sides = 8'(s); bus.count = 3'(c);
    @(posedge clock); #1;
    bus.roll = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_cyc + 1));
    check("dice_values", 64'(bus.dice_values), 64'(exp_v));
    check("total", 64'(bus.total), 64'(exp_tot));
    dv = bus.dice_values;
    @(posedge clock); #1;
    check("done_one_cycle", 64'(bus.done), 64'd0);
  endtask

  logic [31:0] dv, dv_prev, exp_v, nx;
  logic [6:0]  tot_prev;
  int lat, exp_tot, exp_cyc, dones, hist[21];
  int bad_sides[4] = '{1, 21, 6, 6};
  int bad_count[4] = '{1, 1, 0, 5};

  initial begin
    bus.roll = 1'b0; bus.sides = '0; bus.count = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    check("rst_values", 64'(bus.dice_values), 64'd0);
    check("rst_total", 64'(bus.total), 64'd0);
    @(negedge clock) reset = 1'b0;

    do_roll(6, 3, dv, lat);
    for (int unsigned k = 0; k < 3; k++) begin
      check("d6_range", 64'(dv[8*k +: 8] >= 8'd1 && dv[8*k +: 8] <= 8'd6), 64'd1);
    end
    check("d6_slot3_zero", 64'(dv[31:24]), 64'd0);
    do_roll(20, 4, dv, lat);
    do_roll(2, 1, dv, lat);
    do_roll(6, 2, dv, lat);

    dv_prev = bus.dice_values; tot_prev = bus.total;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      bus.roll = 1'b1; bus.sides = 8'(bad_sides[k]); bus.count = 3'(bad_count[k]);
      @(posedge clock); #1;
      bus.roll = 1'b0;
      check("bad_error_hi", 64'(bus.error), 64'd1);
      check("bad_busy", 64'(bus.busy), 64'd0);
      @(posedge clock); #1;
      check("bad_error_lo", 64'(bus.error), 64'd0);
      check("bad_busy2", 64'(bus.busy), 64'd0);
      check("bad_values_held", 64'(bus.dice_values), 64'(dv_prev));
      check("bad_total_held", 64'(bus.total), 64'(tot_prev));
    end

    // Roll held high through ROLL and DONE with junk config: must be ignored.
    @(negedge clock);
    predict(m_lfsr, 6, 3, exp_v, exp_tot, exp_cyc);
    bus.roll = 1'b1; bus.sides = 8'd6; bus.count = 3'd3;
    @(posedge clock); #1;
    bus.sides = 8'd3; bus.count = 3'd1;
    lat = 1; dones = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("hold_latency", 64'(lat), 64'(exp_cyc + 1));
    check("hold_values", 64'(bus.dice_values), 64'(exp_v));
    check("hold_total", 64'(bus.total), 64'(exp_tot));
    if (bus.done) dones++;
    @(posedge clock); #1;
    bus.roll = 1'b0;
    check("hold_busy_after", 64'(bus.busy), 64'd0);
    repeat (8) begin
      @(posedge clock); #1;
      if (bus.done) dones++;
    end
    check("hold_one_done", 64'(dones), 64'd1);

    // Time the request so the first sample lands in the rejection band.
    lat = 0;
    do begin
      @(negedge clock);
      nx = lfsr_step(lfsr_step(m_lfsr));
      lat++;
    end while (nx[7:0] < 8'd240 && lat < 5000);
    check("rej_found", 64'(nx[7:0] >= 8'd240), 64'd1);
    do_roll(20, 1, dv, lat);
    check("rej_latency_ge3", 64'(lat >= 3), 64'd1);
    check("rej_range", 64'(dv[7:0] >= 8'd1 && dv[7:0] <= 8'd20), 64'd1);

    @(negedge clock);
    bus.roll = 1'b1; bus.sides = 8'd20; bus.count = 3'd4;
    @(posedge clock); #1;
    bus.roll = 1'b0;
    @(posedge clock); #1;
    check("mid_busy_pre", 64'(bus.busy), 64'd1);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_done", 64'(bus.done), 64'd0);
    check("mid_values", 64'(bus.dice_values), 64'd0);
    check("mid_total", 64'(bus.total), 64'd0);
    @(negedge clock) reset = 1'b0;

    for (int k = 0; k <= 20; k++) hist[k] = 0;
    for (int n = 0; n < 10000; n++) begin
      do_roll(20, 1, dv, lat);
      if (dv[7:0] <= 8'd20) hist[dv[7:0]]++;
    end
    for (int k = 1; k <= 20; k++) begin
      if (hist[k] < 400 || hist[k] > 600) $display("face %0d hits %0d", k, hist[k]);
      check($sformatf("face_%0d_in_400_600", k), 64'(hist[k] >= 400 && hist[k] <= 600), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
